nand_logic_unit: RTL



---
 rtl/nand_lu_pkg.sv | 27 ++
 rtl/nand_logic_slice.sv | 56 +++++
 rtl/nand_logic_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/nand_lu_pkg.sv
// Shared opcode encoding and NAND-only helper primitives for the logic unit.
package nand_lu_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned NUM_OPS = 1 << OP_W;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd3;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd4;
    localparam logic [OP_W-1:0] OP_NAND = 3'd5;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

    // 2:1 mux from three NANDs plus a NAND-inverter on the select
    function automatic logic mux2(input logic s, input logic d0, input logic d1);
        logic ns;
        ns = nand2(s, s);
        return nand2(nand2(d0, ns), nand2(d1, s));
    endfunction

endpackage

// File: rtl/nand_logic_slice.sv
// One-bit combinational cell: all eight logic functions and the opcode mux,
// built exclusively from 2-input NANDs.
module nand_logic_slice
    import nand_lu_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic [OP_W-1:0] op,
    output logic            y
);

    logic               na;
    logic               nb;
    logic               nab;
    logic               f_and;
    logic               f_or;
    logic               f_nor;
    logic               f_xor;
    logic               f_xnor;
    logic [NUM_OPS-1:0] f;
    logic [3:0]         m0;
    logic [1:0]         m1;

    always_comb begin
        na     = nand2(a, a);
        nb     = nand2(b, b);
        nab    = nand2(a, b);
        f_and  = nand2(nab, nab);
        f_or   = nand2(na, nb);
        f_nor  = nand2(f_or, f_or);
        f_xor  = nand2(nand2(a, nab), nand2(b, nab));
        f_xnor = nand2(f_xor, f_xor);

        f          = '0;
        f[OP_AND]  = f_and;
        f[OP_OR]   = f_or;
        f[OP_XOR]  = f_xor;
        f[OP_XNOR] = f_xnor;
        f[OP_NOT]  = na;
        f[OP_NAND] = nab;
        f[OP_NOR]  = f_nor;
        f[OP_PASS] = a;

        // binary mux tree, LSB of the opcode selects first
        m0 = '0;
        for (int i = 0; i < 4; i++) begin
            m0[i] = mux2(op[0], f[2*i], f[2*i+1]);
        end
        m1 = '0;
        for (int i = 0; i < 2; i++) begin
            m1[i] = mux2(op[1], m0[2*i], m0[2*i+1]);
        end
        y = mux2(op[2], m1[0], m1[1]);
    end

endmodule

// File: rtl/nand_logic_unit.sv
// Two-stage pipelined WIDTH-bit NAND logic unit with valid/ready handshakes,
// result accumulator for chained operations, and a saturating completion counter.
module nand_logic_unit
    import nand_lu_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic             in_chain,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_zero,
    output logic [CNT_W-1:0] op_count
);

    logic             s1_valid;
    logic [OP_W-1:0]  s1_op;
    logic             s1_chain;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s2_valid;
    logic [WIDTH-1:0] acc;

    logic             s2_adv;
    logic             s1_adv;
    logic             in_fire;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] y_c;

    always_comb begin
        s2_adv   = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_adv;
        in_ready = !s1_valid || s2_adv;
        in_fire  = in_valid && in_ready;
        // in-order issue guarantees acc already holds the previous result
        eff_a    = s1_chain ? acc : s1_a;
    end

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_slice
        nand_logic_slice u_slice (
            .a  (eff_a[i]),
            .b  (s1_b[i]),
            .op (s1_op),
            .y  (y_c[i])
        );
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_chain <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_chain <= in_chain;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_y    <= '0;
            out_zero <= 1'b0;
            acc      <= '0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            out_y    <= y_c;
            out_zero <= ~|y_c;
            acc      <= y_c;
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    assign out_valid = s2_valid;

    // Saturating count of output handshakes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (s2_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule
